// File: rtl/threshold_pkg.sv
// threshold_pkg: shared widths, port-id encoding and response tag for the threshold ROM arbiter
package threshold_pkg;
  localparam int ROM_ADDR_W = 16;
  localparam int ROM_DATA_W = 8;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/rom_tag_pipe.sv
// rom_tag_pipe: LAT-deep tag shift register with sync clear, yields per-port read-valid strobes
module rom_tag_pipe
  import threshold_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag,
  output logic a_rvalid,
  output logic b_rvalid
);
  tag_t pipe [LAT];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign a_rvalid = pipe[LAT-1].valid && pipe[LAT-1].port == PORT_A;
  assign b_rvalid = pipe[LAT-1].valid && pipe[LAT-1].port == PORT_B;
endmodule

// File: rtl/threshold_rom_arbiter.sv
// threshold_rom_arbiter: round-robin sharing of the threshold ROM between two readers; THRESHOLD_ROM_ARBITER_STATS_EN adds grant/conflict counters
module threshold_rom_arbiter
  import threshold_pkg::*;
#(
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
  ,
  output logic [31:0]       a_grant_cnt,
  output logic [31:0]       b_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);
  logic              last_gnt;
  logic [ADDR_W-1:0] held_addr;
  tag_t              tag;
  always_comb begin
    a_gnt     = rst_n && a_req && (!b_req || last_gnt == PORT_B);
    b_gnt     = rst_n && b_req && (!a_req || last_gnt == PORT_A);
    rom_addr  = a_gnt ? a_addr : b_gnt ? b_addr : held_addr;
    tag.valid = a_gnt || b_gnt;
    tag.port  = b_gnt ? PORT_B : PORT_A;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt  <= PORT_B;
      held_addr <= '0;
    end else if (tag.valid) begin
      last_gnt  <= tag.port;
      held_addr <= rom_addr;
    end
  end
  rom_tag_pipe #(.LAT(ROM_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag      (tag),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid)
  );
  assign a_rdata = rom_q;
  assign b_rdata = rom_q;
`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_grant_cnt  <= '0;
      b_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_gnt && !(&a_grant_cnt)) a_grant_cnt <= a_grant_cnt + 32'd1;
      if (b_gnt && !(&b_grant_cnt)) b_grant_cnt <= b_grant_cnt + 32'd1;
      if (a_req && b_req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_threshold_rom_arbiter.sv
// tb_threshold_rom_arbiter: directed table-driven bench; DUTs at ROM_LAT=1 and 3 share stimulus, stats checked under THRESHOLD_ROM_ARBITER_STATS_EN
module tb_threshold_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [15:0] a_addr, b_addr;
  logic        a_gnt1, b_gnt1, a_rv1, b_rv1, a_gnt3, b_gnt3, a_rv3, b_rv3;
  logic [7:0]  a_rd1, b_rd1, a_rd3, b_rd3, q1, q3 [3];
  logic [15:0] rom_addr1, rom_addr3;
`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
  logic [31:0] a_cnt1, b_cnt1, c_cnt1, a_cnt3, b_cnt3, c_cnt3;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  threshold_rom_arbiter #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .rom_addr(rom_addr1), .rom_q(q1)
`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
    , .a_grant_cnt(a_cnt1), .b_grant_cnt(b_cnt1), .conflict_cnt(c_cnt1)
`endif
  );

  threshold_rom_arbiter #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt3), .a_rvalid(a_rv3), .a_rdata(a_rd3),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt3), .b_rvalid(b_rv3), .b_rdata(b_rd3),
    .rom_addr(rom_addr3), .rom_q(q3[2])
`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
    , .a_grant_cnt(a_cnt3), .b_grant_cnt(b_cnt3), .conflict_cnt(c_cnt3)
`endif
  );

  // behavioural ROMs: q = addr[7:0] ^ 8'h5A after 1 and 3 cycles
  always @(posedge clk) begin
    q1    <= rom_addr1[7:0] ^ 8'h5A;
    q3[0] <= rom_addr3[7:0] ^ 8'h5A;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end

  typedef struct packed {
    logic        ar, br;
    logic [15:0] aa, ba;
    logic        eag, ebg;
    logic [15:0] era;
    logic        eav, ebv;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic ar, logic br, logic [15:0] aa, logic [15:0] ba, logic eag,
                              logic ebg, logic [15:0] era, logic eav, logic ebv, logic [7:0] ed);
    mk = '{ar, br, aa, ba, eag, ebg, era, eav, ebv, ed};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic br, input logic [15:0] aa, input logic [15:0] ba);
    a_req = ar; b_req = br; a_addr = aa; b_addr = ba;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'h0010, 16'h0020);
    // contention from reset release: A first, then strict alternation
    for (int k = 0; k < 8; k++)
      tbl[k] = mk(1, 1, 16'h0010, 16'h0020, k % 2 == 0, k % 2 == 1,
                  (k % 2 == 0) ? 16'h0010 : 16'h0020, k % 2 == 1, k >= 2 && k % 2 == 0,
                  (k % 2 == 1) ? 8'h4A : 8'h7A);
    tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 0, 1, 8'h7A);
    tbl[9]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 0, 0, 8'h00);
    tbl[10] = mk(0, 1, 16'h0000, 16'h1234, 0, 1, 16'h1234, 0, 0, 8'h00);
    tbl[11] = mk(0, 1, 16'h0000, 16'h00FF, 0, 1, 16'h00FF, 0, 1, 8'h6E);
    tbl[12] = mk(1, 0, 16'h0031, 16'h0000, 1, 0, 16'h0031, 0, 1, 8'hA5);
    tbl[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0031, 1, 0, 8'h6B);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", {31'b0, a_gnt1}, 0);
    chk("rst_b_gnt", {31'b0, b_gnt1}, 0);
    chk("rst_a_rvalid", {31'b0, a_rv1}, 0);
    chk("rst_b_rvalid", {31'b0, b_rv1}, 0);
    chk("rst_rom_addr", {16'b0, rom_addr1}, 0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ar, tbl[i].br, tbl[i].aa, tbl[i].ba);
      @(negedge clk);
      chk($sformatf("v%0d_a_gnt", i), {31'b0, a_gnt1}, {31'b0, tbl[i].eag});
      chk($sformatf("v%0d_b_gnt", i), {31'b0, b_gnt1}, {31'b0, tbl[i].ebg});
      chk($sformatf("v%0d_rom_addr", i), {16'b0, rom_addr1}, {16'b0, tbl[i].era});
      chk($sformatf("v%0d_a_rvalid", i), {31'b0, a_rv1}, {31'b0, tbl[i].eav});
      chk($sformatf("v%0d_b_rvalid", i), {31'b0, b_rv1}, {31'b0, tbl[i].ebv});
      if (tbl[i].eav) chk($sformatf("v%0d_a_rdata", i), {24'b0, a_rd1}, {24'b0, tbl[i].ed});
      if (tbl[i].ebv) chk($sformatf("v%0d_b_rdata", i), {24'b0, b_rd1}, {24'b0, tbl[i].ed});
      next_cycle();
    end

    // A-only stream, addr 0..49, no bubbles
    for (int i = 0; i <= 50; i++) begin
      drive(i < 50, 1'b0, 16'(i), 16'h0000);
      @(negedge clk);
      if (i < 50) begin
        chk($sformatf("aonly%0d_a_gnt", i), {31'b0, a_gnt1}, 1);
        chk($sformatf("aonly%0d_rom_addr", i), {16'b0, rom_addr1}, i);
      end
      chk($sformatf("aonly%0d_a_rvalid", i), {31'b0, a_rv1}, {31'b0, i > 0});
      chk($sformatf("aonly%0d_b_rvalid", i), {31'b0, b_rv1}, 0);
      if (i > 0) chk($sformatf("aonly%0d_a_rdata", i), {24'b0, a_rd1}, {24'b0, 8'(i - 1) ^ 8'h5A});
      next_cycle();
    end

    // ROM_LAT=3: single B read, valid only at N+3
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (4) next_cycle();
    drive(1'b0, 1'b1, 16'h0000, 16'h00FF);
    @(negedge clk);
    chk("lat3_b_gnt", {31'b0, b_gnt3}, 1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      chk($sformatf("lat3_n%0d_b_rvalid", d), {31'b0, b_rv3}, {31'b0, d == 3});
      chk($sformatf("lat3_n%0d_a_rvalid", d), {31'b0, a_rv3}, 0);
      if (d == 3) chk("lat3_b_rdata", {24'b0, b_rd3}, 32'h0000_00A5);
      next_cycle();
    end

    // ROM_LAT=3: reset the cycle after an A accept, tag must vanish
    drive(1'b1, 1'b0, 16'h0077, 16'h0000);
    @(negedge clk);
    chk("midrst_a_gnt", {31'b0, a_gnt3}, 1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      chk($sformatf("midrst_n%0d_a_rvalid", d), {31'b0, a_rv3}, 0);
      next_cycle();
      rst_n = 1'b1;
    end

    // restart prefers A
    drive(1'b1, 1'b1, 16'h0001, 16'h0002);
    @(negedge clk);
    chk("restart_a_gnt", {31'b0, a_gnt3}, 1);
    chk("restart_b_gnt", {31'b0, b_gnt3}, 0);
    next_cycle();

`ifdef THRESHOLD_ROM_ARBITER_STATS_EN
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i >= 10, 16'h0003, 16'h0004);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("stats_a_grant_cnt", a_cnt1, 13);
    chk("stats_b_grant_cnt", b_cnt1, 3);
    chk("stats_conflict_cnt", c_cnt1, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
